// File: rtl/acc_seq_pkg.sv
// Shared constants for the accumulator command sequencer: widths, opcodes
// and the controller state encoding.
package acc_seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int OPW_DEF   = 4;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_LOAD    = 4'd1;
  localparam logic [3:0] OP_CLR     = 4'd2;
  localparam logic [3:0] OP_READ    = 4'd3;
  localparam logic [3:0] OP_ALU_MIN = 4'd4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

endpackage

// File: rtl/acc_sequencer.sv
// Single-outstanding command sequencer driving the parent's ALU and the
// enable-less accumulator register, with a valid/ready response channel.
module acc_sequencer
  import acc_seq_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int OPW     = OPW_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] acc_q,
  output logic [WIDTH-1:0] acc_d,
  output logic             acc_we,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  localparam int CNTW = 2;

  logic [1:0]       state;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNTW-1:0]  cnt;

  logic cmd_resp_only;
  logic cmd_direct_wb;
  logic op_is_load;
  logic op_is_clr;

  assign cmd_resp_only = (cmd_op == OPW'(OP_NOP)) || (cmd_op == OPW'(OP_READ));
  assign cmd_direct_wb = (cmd_op == OPW'(OP_LOAD)) || (cmd_op == OPW'(OP_CLR));
  assign op_is_load    = (op_q == OPW'(OP_LOAD));
  assign op_is_clr     = (op_q == OPW'(OP_CLR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      data_q <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            if (cmd_resp_only) begin
              state <= RESP;
            end else if (cmd_direct_wb) begin
              state <= WB;
            end else begin
              state <= EXEC;
              cnt   <= CNTW'(ALU_LAT - 1);
            end
          end
        end
        // cnt counts the remaining ALU latency cycles; WB samples alu_result.
        EXEC: begin
          if (cnt == '0) begin
            state <= WB;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        WB: begin
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The register has no enable, so every non-WB cycle feeds its own value back.
  always_comb begin
    acc_we = 1'b0;
    acc_d  = acc_q;
    if (state == WB) begin
      acc_we = 1'b1;
      if (op_is_load) begin
        acc_d = data_q;
      end else if (op_is_clr) begin
        acc_d = '0;
      end else begin
        acc_d = alu_result;
      end
    end
  end

  // ALU inputs come from held registers in every state, keeping them quiet.
  assign alu_a     = acc_q;
  assign alu_b     = data_q;
  assign alu_op    = op_q;

  assign cmd_ready = rst_n && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_data  = acc_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_acc_sequencer.sv
// Randomised self-checking bench for acc_sequencer with a bench-side ALU,
// accumulator register and an opcode-level reference model.
module tb_acc_sequencer;

  localparam int WIDTH   = 16;
  localparam int OPW     = 4;
  localparam int ALU_LAT = 3;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OPW-1:0]   cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             acc_we;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] model_acc;

  acc_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .acc_q(acc_q), .acc_d(acc_d), .acc_we(acc_we),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [OPW-1:0] op);
    case (op)
      4'd4:    alu_f = a + b;
      4'd5:    alu_f = a - b;
      4'd6:    alu_f = a & b;
      4'd7:    alu_f = a | b;
      4'd8:    alu_f = a ^ b;
      4'd9:    alu_f = b - a;
      default: alu_f = a + (b ^ 16'h5A5A);
    endcase
  endfunction

  // Parent-side accumulator register and an ALU_LAT-deep pipelined ALU.
  logic [WIDTH-1:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    acc_q <= acc_d;
    alu_pipe[0] <= alu_f(alu_a, alu_b, alu_op);
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_result = alu_pipe[ALU_LAT-1];

  function automatic logic [WIDTH-1:0] model_next(input logic [WIDTH-1:0] acc, input logic [OPW-1:0] op,
                                                  input logic [WIDTH-1:0] data);
    if (op == 4'd0 || op == 4'd3) model_next = acc;
    else if (op == 4'd1)          model_next = data;
    else if (op == 4'd2)          model_next = '0;
    else                          model_next = alu_f(acc, data, op);
  endfunction

  function automatic int model_lat(input logic [OPW-1:0] op);
    if (op == 4'd0 || op == 4'd3)      model_lat = 1;
    else if (op == 4'd1 || op == 4'd2) model_lat = 2;
    else                               model_lat = ALU_LAT + 2;
  endfunction

  function automatic int model_wes(input logic [OPW-1:0] op);
    model_wes = (op == 4'd0 || op == 4'd3) ? 0 : 1;
  endfunction

  // Issues one command, observes the whole transaction, then completes the handshake.
  task automatic send(input logic [OPW-1:0] op, input logic [WIDTH-1:0] data, input int hold,
                      output logic [WIDTH-1:0] rsp, output int lat, output int wes,
                      output logic [WIDTH-1:0] wd, output int exec_n, output logic alu_stable,
                      output logic to);
    logic [WIDTH-1:0] a0;
    int n;
    to = 1'b0; wes = 0; lat = 0; exec_n = 0; alu_stable = 1'b1; wd = 'x; rsp = 'x;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; rsp_ready = 1'b0;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      to = 1'b1;
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    a0 = acc_q;
    cmd_valid = 1'b0;
    cmd_op = OPW'($urandom);
    cmd_data = WIDTH'($urandom);
    while (1) begin
      @(negedge clk);
      lat++;
      if (acc_we === 1'b1) begin
        wes++;
        wd = acc_d;
      end
      if (busy === 1'b1 && acc_we !== 1'b1 && rsp_valid !== 1'b1) begin
        exec_n++;
        if (alu_a !== a0 || alu_b !== data || alu_op !== op) alu_stable = 1'b0;
      end
      if (rsp_valid === 1'b1) break;
      if (lat >= 50) begin
        to = 1'b1;
        return;
      end
    end
    rsp = rsp_data;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; rsp_ready = 1'b0;
    #13;
    tests++;
    if ({cmd_ready, rsp_valid, acc_we, busy} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got rdy/vld/we/busy=%b required 0000",
               {cmd_ready, rsp_valid, acc_we, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_release_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_load;
    logic [WIDTH-1:0] rsp, wd; int lat, wes, ex; logic st, to;
    send(4'd1, 16'h1234, 0, rsp, lat, wes, wd, ex, st, to);
    model_acc = 16'h1234;
    tests++;
    if (to || lat != 2 || wes != 1 || wd !== 16'h1234 || rsp !== 16'h1234) begin
      fails++;
      $display("[TB] FAIL load: got to=%0b lat=%0d we=%0d acc_d=%h rsp=%h required lat=2 we=1 acc_d=1234 rsp=1234",
               to, lat, wes, wd, rsp);
    end
  endtask

  task automatic test_alu;
    logic [WIDTH-1:0] rsp, wd; int lat, wes, ex; logic st, to;
    send(4'd1, 16'h0005, 0, rsp, lat, wes, wd, ex, st, to);
    send(4'd4, 16'h0003, 0, rsp, lat, wes, wd, ex, st, to);
    model_acc = 16'h0008;
    tests++;
    if (to || rsp !== 16'h0008 || lat != ALU_LAT + 2) begin
      fails++;
      $display("[TB] FAIL alu_add: got to=%0b rsp=%h lat=%0d required rsp=0008 lat=%0d",
               to, rsp, lat, ALU_LAT + 2);
    end
    tests++;
    if (ex != ALU_LAT || st !== 1'b1) begin
      fails++;
      $display("[TB] FAIL alu_operands: got exec_cycles=%0d stable=%b required %0d and 1",
               ex, st, ALU_LAT);
    end
  endtask

  task automatic test_overflow;
    logic [WIDTH-1:0] rsp, wd; int lat, wes, ex; logic st, to;
    send(4'd1, 16'hFFFF, 0, rsp, lat, wes, wd, ex, st, to);
    send(4'd4, 16'h0002, 1, rsp, lat, wes, wd, ex, st, to);
    model_acc = 16'h0001;
    tests++;
    if (to || rsp !== 16'h0001 || wd !== 16'h0001) begin
      fails++;
      $display("[TB] FAIL add_overflow: got to=%0b rsp=%h acc_d=%h required 0001", to, rsp, wd);
    end
  endtask

  task automatic test_backpressure;
    int bad;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd3; cmd_data = 16'h7777; rsp_ready = 1'b0;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL bp_idle_ready: got %b required 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_op = 4'd1; cmd_data = 16'hABCD;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== model_acc || cmd_ready !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL bp_hold: got %0d bad cycles (last vld=%b data=%h rdy=%b) required 0 with data=%h",
               bad, rsp_valid, rsp_data, cmd_ready, model_acc);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bp_after_handshake: got rdy=%b busy=%b required 1 0", cmd_ready, busy);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (acc_we !== 1'b1 || acc_d !== 16'hABCD) begin
      fails++;
      $display("[TB] FAIL bp_pending_load: got we=%b acc_d=%h required 1 abcd", acc_we, acc_d);
    end
    @(negedge clk);
    model_acc = 16'hABCD;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hABCD) begin
      fails++;
      $display("[TB] FAIL bp_pending_rsp: got vld=%b data=%h required 1 abcd", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_clr_read_nop;
    logic [WIDTH-1:0] r0, r1, r2, wd; int lat, w0, w1, w2, ex; logic st, t0, t1, t2;
    send(4'd2, 16'h5555, 0, r0, lat, w0, wd, ex, st, t0);
    send(4'd3, 16'h1111, 0, r1, lat, w1, wd, ex, st, t1);
    send(4'd0, 16'h2222, 2, r2, lat, w2, wd, ex, st, t2);
    model_acc = '0;
    tests++;
    if (t0 || t1 || t2 || r0 !== 16'h0 || r1 !== 16'h0 || r2 !== 16'h0) begin
      fails++;
      $display("[TB] FAIL clr_read_nop_rsp: got %h %h %h required 0000 0000 0000", r0, r1, r2);
    end
    tests++;
    if (w0 + w1 + w2 != 1) begin
      fails++;
      $display("[TB] FAIL clr_read_nop_we: got %0d pulses required 1", w0 + w1 + w2);
    end
  endtask

  task automatic test_reset_mid_exec;
    logic [WIDTH-1:0] rsp, wd; int lat, wes, ex, bad; logic st, to;
    send(4'd1, 16'h00F0, 0, rsp, lat, wes, wd, ex, st, to);
    model_acc = 16'h00F0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd4; cmd_data = 16'h0007;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || acc_we !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_exec_state: got busy=%b we=%b vld=%b required 1 0 0", busy, acc_we, rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({cmd_ready, busy, rsp_valid, acc_we} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL mid_exec_reset: got rdy/busy/vld/we=%b required 0000",
               {cmd_ready, busy, rsp_valid, acc_we});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_exec_release_ready: got %b required 1", cmd_ready);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (acc_we !== 1'b0 || rsp_valid !== 1'b0 || acc_q !== model_acc) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL mid_exec_abort: got %0d bad cycles acc=%h required 0 acc=%h", bad, acc_q, model_acc);
    end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] rsp, wd, data, exp; logic [OPW-1:0] op; int lat, wes, ex, hold; logic st, to;
    for (int k = 0; k < 40; k++) begin
      op   = OPW'($urandom_range(0, 15));
      data = WIDTH'($urandom);
      hold = $urandom_range(0, 3);
      exp  = model_next(model_acc, op, data);
      send(op, data, hold, rsp, lat, wes, wd, ex, st, to);
      tests++;
      if (to || rsp !== exp || lat != model_lat(op) || wes != model_wes(op)) begin
        fails++;
        $display("[TB] FAIL random_%0d op=%0d data=%h: got to=%0b rsp=%h lat=%0d we=%0d required rsp=%h lat=%0d we=%0d",
                 k, op, data, to, rsp, lat, wes, exp, model_lat(op), model_wes(op));
      end
      if (op >= 4'd4) begin
        tests++;
        if (ex != ALU_LAT || st !== 1'b1) begin
          fails++;
          $display("[TB] FAIL random_alu_inputs_%0d: got exec=%0d stable=%b required %0d 1", k, ex, st, ALU_LAT);
        end
      end
      model_acc = exp;
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_alu;
    test_overflow;
    test_backpressure;
    test_clr_read_nop;
    test_reset_mid_exec;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Command sequencer for the 16-bit ALU datapath and its accumulator register.
- Accepts one command at a time over a valid/ready interface and drives the ALU operands and opcode.
- Waits a configurable ALU latency, writes the result into the accumulator register, then returns the new accumulator value over a valid/ready response channel.
- The accumulator register is the plain 16-bit posedge register in the parent. It has no enable, so this block drives its D input every cycle.

Parameters:
- WIDTH, 16, datapath width.
- OPW, 4, opcode width.
- ALU_LAT, 1, cycles from ALU inputs stable to alu_result valid; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts command
- cmd_op  in  OPW  command opcode
- cmd_data  in  WIDTH  command operand
- acc_q  in  WIDTH  accumulator register output
- acc_d  out  WIDTH  accumulator register input
- acc_we  out  1  high in the cycle acc_d carries a new value (observability)
- alu_a  out  WIDTH  ALU operand A
- alu_b  out  WIDTH  ALU operand B
- alu_op  out  OPW  ALU opcode
- alu_result  in  WIDTH  ALU result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  WIDTH  accumulator value after the command
- busy  out  1  state is not IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, op_q=0, data_q=0, cnt=0, rsp_valid=0, acc_we=0, busy=0. cmd_ready reads 0 while rst_n=0 and 1 in IDLE afterwards.
- Reset mid-command aborts it: no accumulator write occurs after the reset edge and no response is issued. The accumulator register is not reset; software issues CLR.
- Opcodes:
  - 0 NOP: response only.
  - 1 LOAD: acc<=cmd_data.
  - 2 CLR: acc<=0.
  - 3 READ: response only.
  - 4..15 ALU: acc<=alu_result, with alu_op=cmd_op.
- States: IDLE, EXEC, WB, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op_q/data_q, then:
  - NOP/READ go to RESP.
  - LOAD/CLR go to WB.
  - ALU ops go to EXEC with cnt=ALU_LAT-1.
- EXEC: alu_a=acc_q, alu_b=data_q, alu_op=op_q, all held stable. Decrement cnt; when cnt==0, go to WB.
- WB: one cycle. acc_we=1, acc_d=data_q (LOAD), 0 (CLR) or alu_result (ALU); the register captures on that edge. Next state is RESP.
- RESP: rsp_valid=1, rsp_data=acc_q (already updated). Hold until rsp_ready. On the handshake edge go to IDLE. rsp_data is stable while rsp_valid=1 and rsp_ready=0.
- In every non-WB cycle: acc_we=0, acc_d=acc_q (hold).
- Outside EXEC: alu_a=acc_q, alu_b=data_q, alu_op=op_q. This keeps the ALU inputs quiet.
- cmd_ready=0 in EXEC, WB and RESP; only one command is outstanding.
- Latency from the accept edge to rsp_valid: NOP/READ 1 cycle, LOAD/CLR 2 cycles, ALU ALU_LAT+2 cycles.
- A new command is accepted at the earliest in the cycle after the response handshake.
- Arithmetic is modulo 2^WIDTH. Overflow is the ALU's concern and is not flagged here.
- cmd_op/cmd_data are sampled only at the accept edge. Later changes are ignored.

Decomposition:
- Shared package acc_seq_pkg holds:
  - WIDTH and OPW defaults;
  - opcode constants OP_NOP, OP_LOAD, OP_CLR, OP_READ, OP_ALU_MIN=4;
  - state encoding IDLE=0, EXEC=1, WB=2, RESP=3.
- No sub-module. The accumulator register and the ALU stay instantiated in the parent.

Test Plan:
- Reset low mid-EXEC, then release -> no acc_we pulse, no rsp_valid; cmd_ready=1 on the first cycle after release.
- LOAD 16'h1234 with rsp_ready=1 -> acc_we pulse 1 cycle after accept with acc_d=16'h1234; rsp_valid 2 cycles after accept, rsp_data=16'h1234.
- ALU_LAT=3, acc=16'h0005, op 4 (ADD by bench ALU model), data 16'h0003 -> alu_a/alu_b/alu_op stable (5,3,4) for 3 cycles; rsp_data=16'h0008 at 5 cycles after accept.
- ADD overflow: acc=16'hFFFF, op 4, data 16'h0002 -> rsp_data=16'h0001.
- Backpressure: READ with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_data held; cmd_ready=0 throughout; a pending cmd_valid is accepted only after the rsp handshake.
- CLR, then READ, then NOP -> responses 16'h0000, 16'h0000, 16'h0000; exactly one acc_we pulse in total (from CLR).
